// File: rtl/word_assembler.sv
// word_assembler: packs accepted bytes into BYTES-wide words with a paired, wrapping address.
// Define WORD_ASSEMBLER_TIMEOUT_EN to discard partial words left idle for TIMEOUT_CYC cycles.
module word_assembler #(
   parameter int BYTES       = 2,
   parameter int ADDR_W      = 8,
   parameter int MSB_FIRST   = 1,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [7:0]                   in_data,
   output logic                         in_ready,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [8*BYTES-1:0]           data,
   output logic [ADDR_W-1:0]            addr,
   output logic [$clog2(BYTES+1)-1:0]   byte_cnt,
   output logic                         wrap,
   output logic                         timeout_err
);
   localparam int CW = $clog2(BYTES + 1);
   if (BYTES < 2 || BYTES > 8 || ADDR_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("word_assembler: illegal parameter set");
   end
   typedef enum logic {COLLECT, HOLD} state_t;
   state_t state, state_nxt;
   logic [8*BYTES-1:0] stage, word_nxt;
   logic [CW-1:0] lane;
   logic accept, take, last, handshake, tmo;
   assign out_valid = state == HOLD;
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign take      = accept && !flush;
   assign last      = take && byte_cnt == CW'(BYTES - 1);
   assign handshake = out_valid && out_ready;
   assign lane      = MSB_FIRST != 0 ? CW'(BYTES - 1) - byte_cnt : byte_cnt;
   always_comb begin
      word_nxt = stage;
      word_nxt[{lane, 3'b000} +: 8] = in_data;
   end
   always_comb begin
      state_nxt = last ? HOLD : handshake ? COLLECT : state;
   end
   // The staging register keeps partial lanes off data until a full word is in.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= COLLECT;
         byte_cnt <= '0;
         addr     <= '0;
         data     <= '0;
         stage    <= '0;
         wrap     <= 1'b0;
      end else begin
         state    <= state_nxt;
         wrap     <= handshake && &addr;
         byte_cnt <= (flush || last || tmo) ? '0 : take ? byte_cnt + 1'b1 : byte_cnt;
         if (handshake) addr <= addr + 1'b1;
         if (take) stage <= word_nxt;
         if (last) data <= word_nxt;
      end
   end
`ifdef WORD_ASSEMBLER_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT_CYC + 1);
   logic [IW-1:0] idle_cnt;
   logic idle;
   assign idle = byte_cnt != '0 && !accept && !flush;
   assign tmo  = idle && idle_cnt == IW'(TIMEOUT_CYC - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= tmo;
         idle_cnt    <= (idle && !tmo) ? idle_cnt + 1'b1 : '0;
      end
   end
`else
   assign tmo         = 1'b0;
   assign timeout_err = 1'b0;
`endif
endmodule
